// File: rtl/spi_ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_arb_pkg
// Description : Shared types and widths for the SPI RAM two-requester arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_ram_arb_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    // Command field carried in bits [9:8] of every word sent to the RAM
    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    // Arbiter states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_e;

endpackage : spi_ram_arb_pkg
`default_nettype wire

// File: rtl/spi_ram_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_arb_rr
// Description : Two-way round-robin grant. The priority pointer moves to the
//               requester that did not own the transaction that just ended.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_arb_rr (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic end_i,
    input  logic end_owner_i,
    output logic grant_o,
    output logic any_o
);

    logic rr_q;

    // Pointer requester wins when it is valid, otherwise the other one
    always_comb begin
        grant_o = rr_q;
        if (rr_q ? !valid1_i : !valid0_i) begin
            grant_o = ~rr_q;
        end
    end

    assign any_o = valid0_i | valid1_i;

    // Hand priority to the non-owner whenever a transaction completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else if (end_i) begin
            rr_q <= ~end_owner_i;
        end
    end

endmodule : spi_ram_arb_rr
`default_nettype wire

// File: rtl/spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_arbiter
// Description : Shares the single-port RAM command interface between two
//               requesters. A requester keeps the RAM locked from its address
//               word until its data word (or read response) so the RAM's
//               internal address registers are never interleaved. Read data
//               is returned to the requester that issued the read.
//               Optional owner-stall watchdog: SPI_RAM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_arbiter
    import spi_ram_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid_i,
    input  logic [CMD_W-1:0]  req0_data_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [CMD_W-1:0]  req1_data_i,
    output logic              req1_ready_o,
    output logic              rsp0_valid_o,
    output logic [DATA_W-1:0] rsp0_data_o,
    output logic              rsp1_valid_o,
    output logic [DATA_W-1:0] rsp1_data_o,
    output logic [CMD_W-1:0]  ram_din_o,
    output logic              ram_rx_valid_o,
    input  logic [DATA_W-1:0] ram_dout_i,
    input  logic              ram_tx_valid_i,
    output logic              timeout_err_o
);

    state_e             state_q;
    logic               owner_q;
    logic [CMD_W-1:0]   ram_din_q;
    logic               ram_rx_valid_q;
    logic               rsp0_valid_q;
    logic               rsp1_valid_q;
    logic [DATA_W-1:0]  rsp0_data_q;
    logic [DATA_W-1:0]  rsp1_data_q;

    logic               w_grant;
    logic               w_any;
    logic               w_rdy0;
    logic               w_rdy1;
    logic               w_acc;
    logic               w_src;
    logic [CMD_W-1:0]   w_word;
    cmd_e               w_cmd;
    logic               w_rsp;
    logic               w_expire;
    logic               w_end;
    logic               w_end_owner;

    spi_ram_arb_rr u_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid0_i    (req0_valid_i),
        .valid1_i    (req1_valid_i),
        .end_i       (w_end),
        .end_owner_i (w_end_owner),
        .grant_o     (w_grant),
        .any_o       (w_any)
    );

    // Readies depend only on state, owner, pointer and valids
    always_comb begin
        w_rdy0 = 1'b0;
        w_rdy1 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                w_rdy0 = w_any && !w_grant;
                w_rdy1 = w_any &&  w_grant;
            end
            ST_LOCKED: begin
                w_rdy0 = !owner_q;
                w_rdy1 =  owner_q;
            end
            default: begin
                w_rdy0 = 1'b0;
                w_rdy1 = 1'b0;
            end
        endcase
    end

    // At most one ready is high, so the accepted source is simply ready1
    assign w_acc       = (req0_valid_i && w_rdy0) || (req1_valid_i && w_rdy1);
    assign w_src       = w_rdy1;
    assign w_word      = w_src ? req1_data_i : req0_data_i;
    assign w_cmd       = cmd_e'(w_word[CMD_W-1:CMD_W-2]);
    assign w_rsp       = (state_q == ST_WAIT_RD) && ram_tx_valid_i;
    assign w_end       = (w_acc && (w_cmd == CMD_WR_DATA)) || w_rsp || w_expire;
    assign w_end_owner = w_acc ? w_src : owner_q;

`ifdef SPI_RAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_err_q;

    // The cycle in which the stall count reaches TIMEOUT forces a release;
    // an accept or a read response in that same cycle takes precedence
    assign w_expire = (state_q != ST_IDLE) && !w_acc && !w_rsp &&
                      (cnt_q == CNT_W'(TIMEOUT - 1));

    // Stall counter: zero in IDLE and on every owner accept, counts otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= w_expire;
            if (w_acc || (state_q == ST_IDLE)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign timeout_err_o = timeout_err_q;
`else
    assign w_expire = 1'b0;
    // No watchdog: the flag can never fire (a negative TIMEOUT is meaningless)
    assign timeout_err_o = (TIMEOUT < 0);
`endif

    // Main FSM: forwards accepted words, routes read data, releases the lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            owner_q        <= 1'b0;
            ram_din_q      <= '0;
            ram_rx_valid_q <= 1'b0;
            rsp0_valid_q   <= 1'b0;
            rsp1_valid_q   <= 1'b0;
            rsp0_data_q    <= '0;
            rsp1_data_q    <= '0;
        end else begin
            ram_rx_valid_q <= 1'b0;
            rsp0_valid_q   <= 1'b0;
            rsp1_valid_q   <= 1'b0;
            if (w_acc) begin
                owner_q        <= w_src;
                ram_din_q      <= w_word;
                ram_rx_valid_q <= 1'b1;
                case (w_cmd)
                    CMD_WR_DATA: state_q <= ST_IDLE;
                    CMD_RD_DATA: state_q <= ST_WAIT_RD;
                    default:     state_q <= ST_LOCKED;
                endcase
            end else if (w_rsp) begin
                if (owner_q) begin
                    rsp1_data_q  <= ram_dout_i;
                    rsp1_valid_q <= 1'b1;
                end else begin
                    rsp0_data_q  <= ram_dout_i;
                    rsp0_valid_q <= 1'b1;
                end
                state_q <= ST_IDLE;
            end else if (w_expire) begin
                state_q <= ST_IDLE;
            end
        end
    end

    assign req0_ready_o   = w_rdy0;
    assign req1_ready_o   = w_rdy1;
    assign ram_din_o      = ram_din_q;
    assign ram_rx_valid_o = ram_rx_valid_q;
    assign rsp0_valid_o   = rsp0_valid_q;
    assign rsp0_data_o    = rsp0_data_q;
    assign rsp1_valid_o   = rsp1_valid_q;
    assign rsp1_data_o    = rsp1_data_q;

endmodule : spi_ram_arbiter
`default_nettype wire

// File: tb/tb_spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_ram_arbiter
// Description : Self-checking bench for spi_ram_arbiter: per-cycle vector
//               table plus hand-written reset and watchdog sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_ram_arbiter;

`ifdef SPI_RAM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0;
    logic [9:0] req0_data = '0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [9:0] req1_data = '0;
    logic       req1_ready;
    logic       rsp0_valid;
    logic [7:0] rsp0_data;
    logic       rsp1_valid;
    logic [7:0] rsp1_data;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout = '0;
    logic       ram_tx_valid = 1'b0;
    logic       timeout_err;

    always #5 clk = ~clk;

    spi_ram_arbiter #(.TIMEOUT(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_valid_i   (req0_valid),
        .req0_data_i    (req0_data),
        .req0_ready_o   (req0_ready),
        .req1_valid_i   (req1_valid),
        .req1_data_i    (req1_data),
        .req1_ready_o   (req1_ready),
        .rsp0_valid_o   (rsp0_valid),
        .rsp0_data_o    (rsp0_data),
        .rsp1_valid_o   (rsp1_valid),
        .rsp1_data_o    (rsp1_data),
        .ram_din_o      (ram_din),
        .ram_rx_valid_o (ram_rx_valid),
        .ram_dout_i     (ram_dout),
        .ram_tx_valid_i (ram_tx_valid),
        .timeout_err_o  (timeout_err)
    );

    // {rdy0, rdy1, rx_valid, din, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, err}
    logic [31:0] obs;
    assign obs = {req0_ready, req1_ready, ram_rx_valid, ram_din,
                  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, timeout_err};

    typedef struct {
        logic        v0;
        logic [9:0]  d0;
        logic        v1;
        logic [9:0]  d1;
        logic        txv;
        logic [7:0]  dout;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [31:0] pk(input logic r0, input logic r1, input logic rxv,
                                       input logic [9:0] din, input logic s0v,
                                       input logic [7:0] s0d, input logic s1v,
                                       input logic [7:0] s1d, input logic err);
        return {r0, r1, rxv, din, s0v, s0d, s1v, s1d, err};
    endfunction

    task automatic add(input logic v0, input logic [9:0] d0, input logic v1,
                       input logic [9:0] d1, input logic txv, input logic [7:0] dout,
                       input logic r0, input logic r1, input logic rxv,
                       input logic [9:0] din, input logic s0v, input logic [7:0] s0d,
                       input logic s1v, input logic [7:0] s1d);
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.txv = txv; v.dout = dout;
        v.exp = pk(r0, r1, rxv, din, s0v, s0d, s1v, s1d, 1'b0);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic v0, input logic [9:0] d0, input logic v1,
                         input logic [9:0] d1, input logic txv, input logic [7:0] dout);
        req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
        ram_tx_valid = txv; ram_dout = dout;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    initial begin
        // Inputs are applied for one cycle per row; expectations are sampled in
        // that cycle: readies for this row's inputs, registered outputs from the
        // previous row.
        //   v0  d0      v1  d1      txv dout  | r0 r1 rxv din     s0v s0d   s1v s1d
        add(0, 10'h000, 0, 10'h000, 0, 8'h00,   0, 0, 0, 10'h000, 0, 8'h00, 0, 8'h00);
        add(1, 10'h005, 0, 10'h000, 0, 8'h00,   1, 0, 0, 10'h000, 0, 8'h00, 0, 8'h00);
        add(1, 10'h1A5, 0, 10'h000, 0, 8'h00,   1, 0, 1, 10'h005, 0, 8'h00, 0, 8'h00);
        add(1, 10'h205, 0, 10'h000, 0, 8'h00,   1, 0, 1, 10'h1A5, 0, 8'h00, 0, 8'h00);
        add(1, 10'h300, 0, 10'h000, 0, 8'h00,   1, 0, 1, 10'h205, 0, 8'h00, 0, 8'h00);
        add(0, 10'h000, 0, 10'h000, 0, 8'h00,   0, 0, 1, 10'h300, 0, 8'h00, 0, 8'h00);
        add(1, 10'h005, 1, 10'h011, 1, 8'hA5,   0, 0, 0, 10'h300, 0, 8'h00, 0, 8'h00);
        add(0, 10'h000, 0, 10'h000, 0, 8'h00,   0, 0, 0, 10'h300, 1, 8'hA5, 0, 8'h00);
        add(0, 10'h000, 0, 10'h000, 1, 8'h5A,   0, 0, 0, 10'h300, 0, 8'hA5, 0, 8'h00);
        add(0, 10'h000, 0, 10'h000, 0, 8'h00,   0, 0, 0, 10'h300, 0, 8'hA5, 0, 8'h00);
        add(0, 10'h000, 1, 10'h207, 0, 8'h00,   0, 1, 0, 10'h300, 0, 8'hA5, 0, 8'h00);
        add(1, 10'h010, 1, 10'h300, 0, 8'h00,   0, 1, 1, 10'h207, 0, 8'hA5, 0, 8'h00);
        add(1, 10'h010, 0, 10'h000, 1, 8'h3C,   0, 0, 1, 10'h300, 0, 8'hA5, 0, 8'h00);
        add(1, 10'h010, 1, 10'h020, 0, 8'h00,   1, 0, 0, 10'h300, 0, 8'hA5, 1, 8'h3C);
        add(0, 10'h000, 1, 10'h020, 0, 8'h00,   1, 0, 1, 10'h010, 0, 8'hA5, 0, 8'h3C);
        add(1, 10'h1FF, 1, 10'h020, 0, 8'h00,   1, 0, 0, 10'h010, 0, 8'hA5, 0, 8'h3C);
        add(0, 10'h000, 1, 10'h020, 0, 8'h00,   0, 1, 1, 10'h1FF, 0, 8'hA5, 0, 8'h3C);
        add(1, 10'h030, 1, 10'h1EE, 0, 8'h00,   0, 1, 1, 10'h020, 0, 8'hA5, 0, 8'h3C);
        add(1, 10'h040, 1, 10'h050, 0, 8'h00,   1, 0, 1, 10'h1EE, 0, 8'hA5, 0, 8'h3C);
        add(1, 10'h141, 1, 10'h050, 0, 8'h00,   1, 0, 1, 10'h040, 0, 8'hA5, 0, 8'h3C);
        add(1, 10'h042, 1, 10'h050, 0, 8'h00,   0, 1, 1, 10'h141, 0, 8'hA5, 0, 8'h3C);
        add(1, 10'h042, 1, 10'h151, 0, 8'h00,   0, 1, 1, 10'h050, 0, 8'hA5, 0, 8'h3C);
        add(1, 10'h042, 1, 10'h052, 0, 8'h00,   1, 0, 1, 10'h151, 0, 8'hA5, 0, 8'h3C);
        add(1, 10'h143, 1, 10'h052, 0, 8'h00,   1, 0, 1, 10'h042, 0, 8'hA5, 0, 8'h3C);
        add(0, 10'h000, 0, 10'h000, 0, 8'h00,   0, 0, 1, 10'h143, 0, 8'hA5, 0, 8'h3C);
        add(0, 10'h000, 0, 10'h000, 0, 8'h00,   0, 0, 0, 10'h143, 0, 8'hA5, 0, 8'h3C);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) @(negedge clk);
            drive(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].txv, vecs[i].dout);
            #1;
            chk($sformatf("vec%0d", i), obs, vecs[i].exp);
        end

        // Asynchronous reset while req1 waits for read data (pointer is 1 here)
        @(negedge clk);
        drive(1'b0, '0, 1'b1, 10'h2AA, 1'b0, '0);
        #1;
        chk("rst_pre_grant", {30'd0, req0_ready, req1_ready}, 32'd1);
        @(negedge clk);
        drive(1'b0, '0, 1'b1, 10'h300, 1'b0, '0);
        #1;
        chk("rst_pre_locked", {30'd0, req0_ready, req1_ready}, 32'd1);
        @(negedge clk);
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
        #1;
        chk("rst_pre_wait", obs, pk(0, 0, 1, 10'h300, 0, 8'hA5, 0, 8'h3C, 0));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_clear", obs, 32'd0);
        @(negedge clk);
        #1;
        chk("rst_held_clear", obs, 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 10'h0AB, 1'b1, 10'h0CD, 1'b0, '0);
        #1;
        chk("rst_post_grant", {30'd0, req0_ready, req1_ready}, 32'd2);
        @(negedge clk);
        #1;
        chk("rst_post_fwd", {19'd0, req1_ready, ram_rx_valid, ram_din, 1'b0},
            {19'd0, 1'b0, 1'b1, 10'h0AB, 1'b0});

        // Owner stalls after an address word while req1 waits
        do_reset();
        drive(1'b1, 10'h010, 1'b1, 10'h020, 1'b0, '0);
        #1;
        chk("to_first_grant", {30'd0, req0_ready, req1_ready}, 32'd2);
        @(negedge clk);
        req0_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            chk($sformatf("to_cyc%0d", k), {30'd0, timeout_err, req1_ready},
                {30'd0, TO_EN && (k == 9), TO_EN && (k >= 9)});
            if (k == 1) begin
                chk("to_fwd_010", {21'd0, ram_rx_valid, ram_din}, {21'd0, 1'b1, 10'h010});
            end
            if (k == 10) begin
                chk("to_fwd_after", {21'd0, ram_rx_valid, ram_din},
                    {21'd0, TO_EN, TO_EN ? 10'h020 : 10'h010});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_spi_ram_arbiter
`default_nettype wire
